// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Bit-serial SLL/SRL/SRA/ROL unit, one position per clock.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_shift = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  localparam logic [1:0] c_op_sll = 2'd0;
  localparam logic [1:0] c_op_srl = 2'd1;
  localparam logic [1:0] c_op_sra = 2'd2;

  localparam logic [SHW-1:0] c_cnt_one = {{(SHW-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted = r_shreg;
    case (r_op)
      c_op_sll: w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      c_op_srl: w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      c_op_sra: w_shifted = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      default:  w_shifted = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
    endcase
  end

  // Operands are latched at the start edge so later input changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_idle;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_op     <= c_op_sll;
      r_result <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start) begin
            r_shreg <= a;
            r_cnt   <= shamt;
            r_op    <= op;
            r_state <= c_shift;
          end
        end
        c_shift: begin
          if (r_cnt != '0) begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt - c_cnt_one;
          end else begin
            r_result <= r_shreg;
            r_state  <= c_done;
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign busy   = (r_state != c_idle);
  assign done   = (r_state == c_done);
  assign result = r_result;

endmodule
`default_nettype wire
